dsp_ctrl_clk_unit: RTL and testbench

Control and clocking hub of the DSP chiplet. It combines three functions:
- a 5-bit configuration register;
- a block-sequencing FSM that runs either the FIR path or the FFT path on each input block, then the DMA output stage;
- three glitch-free gated clocks (FIR, FFT, DMA) derived from the system clock.

It sits between the input buffer (ready_for_processing), the processing cores (fir_done/fft_done) and the DMA/output path.

---
 rtl/dsp_ctrl_clk_unit.sv | 140 ++++++++++++++
 tb/tb_dsp_ctrl_clk_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_ctrl_clk_unit.sv
// dsp_ctrl_clk_unit: control and clocking hub of the DSP chiplet.
// Holds the 5-bit configuration word and sequences each input block through
// the FIR or FFT path and then the DMA output stage.
// Derives three glitch-free gated clocks from clk, one per stage.
`timescale 1ns/1ps

module dsp_ctrl_clk_unit #(
    parameter int BLOCK_SIZE = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       write_enable,
    input  logic [4:0] config_in,
    input  logic       ready_for_processing,
    input  logic       fir_done,
    input  logic       fft_done,
    output logic [4:0] config_mode,
    output logic       start_fir,
    output logic       start_fft,
    output logic       start_dma_out,
    output logic       processing_active,
    output logic       clk_fir,
    output logic       clk_fft,
    output logic       clk_dma
);

    localparam int CW = $clog2(BLOCK_SIZE) + 1;
    localparam logic [CW-1:0] DMA_LAST = CW'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIR  = 2'd1,
        FFT  = 2'd2,
        DMA  = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] dma_count;
    logic          dma_enter;
    logic          en_fir_lat;
    logic          en_fft_lat;
    logic          en_dma_lat;

    // Configuration register; bit 0 picks the path, the upper bits are only stored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            config_mode <= 5'b00000;
        end else if (write_enable) begin
            config_mode <= config_in;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; the path is chosen from the config bit seen when the run starts,
    // so later writes cannot redirect a run already in progress.
    always_comb begin
        next_state = state;
        dma_enter  = 1'b0;
        case (state)
            IDLE: begin
                if (ready_for_processing) begin
                    next_state = config_mode[0] ? FFT : FIR;
                end
            end
            FIR: begin
                if (fir_done) begin
                    next_state = DMA;
                    dma_enter  = 1'b1;
                end
            end
            FFT: begin
                if (fft_done) begin
                    next_state = DMA;
                    dma_enter  = 1'b1;
                end
            end
            DMA: begin
                if (dma_count == DMA_LAST) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // DMA beat counter: cleared on entry to DMA, counts every cycle spent there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dma_count <= '0;
        end else if (dma_enter) begin
            dma_count <= '0;
        end else if (state == DMA) begin
            dma_count <= dma_count + 1'b1;
        end
    end

    // Stage strobes registered from the next state so they are clean flop outputs
    // that change only just after a rising edge (safe to feed the clock-gate latches).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_fir         <= 1'b0;
            start_fft         <= 1'b0;
            start_dma_out     <= 1'b0;
            processing_active <= 1'b0;
        end else begin
            start_fir         <= (next_state == FIR);
            start_fft         <= (next_state == FFT);
            start_dma_out     <= (next_state == DMA);
            processing_active <= (next_state != IDLE);
        end
    end

    // Clock-gate enable latches: transparent while clk is low, so an enable change
    // can never cut a high phase short; reset forces every gate closed.
    always_latch begin
        if (reset) begin
            en_fir_lat <= 1'b0;
            en_fft_lat <= 1'b0;
            en_dma_lat <= 1'b0;
        end else if (!clk) begin
            en_fir_lat <= start_fir;
            en_fft_lat <= start_fft;
            en_dma_lat <= start_dma_out;
        end
    end

    assign clk_fir = clk & en_fir_lat;
    assign clk_fft = clk & en_fft_lat;
    assign clk_dma = clk & en_dma_lat;

endmodule

// File: tb/tb_dsp_ctrl_clk_unit.sv
// Testbench for dsp_ctrl_clk_unit: directed runs plus randomized traffic,
// checked every cycle against a block-level behavioural model.
`timescale 1ns/1ps

module tb_dsp_ctrl_clk_unit;

    localparam int BS = 256;
    localparam time HALF = 5;

    // Model stage codes (bench-only abstraction of where a block is).
    localparam int ST_NONE = 0;
    localparam int ST_FIR  = 1;
    localparam int ST_FFT  = 2;
    localparam int ST_DMA  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       write_enable;
    logic [4:0] config_in;
    logic       ready_for_processing;
    logic       fir_done;
    logic       fft_done;
    logic [4:0] config_mode;
    logic       start_fir;
    logic       start_fft;
    logic       start_dma_out;
    logic       processing_active;
    logic       clk_fir;
    logic       clk_fft;
    logic       clk_dma;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    logic [4:0] m_cfg;
    int         m_stage;
    int         m_left;
    int         exp_fir_edges = 0;
    int         exp_fft_edges = 0;
    int         exp_dma_edges = 0;
    int         act_fir_edges = 0;
    int         act_fft_edges = 0;
    int         act_dma_edges = 0;
    time        rise_fir = 0;
    time        rise_fft = 0;
    time        rise_dma = 0;
    bit         cmp_en = 1'b0;

    dsp_ctrl_clk_unit #(.BLOCK_SIZE(BS)) dut (
        .clk                  (clk),
        .reset                (reset),
        .write_enable         (write_enable),
        .config_in            (config_in),
        .ready_for_processing (ready_for_processing),
        .fir_done             (fir_done),
        .fft_done             (fft_done),
        .config_mode          (config_mode),
        .start_fir            (start_fir),
        .start_fft            (start_fft),
        .start_dma_out        (start_dma_out),
        .processing_active    (processing_active),
        .clk_fir              (clk_fir),
        .clk_fft              (clk_fft),
        .clk_dma              (clk_dma)
    );

    always #HALF clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a block waits for ready, runs on the path chosen by the config bit at
    // that moment, then spends exactly BS cycles in DMA. Gated edges are expected
    // on every clk edge where the stage was already active before the edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cfg   = 5'b00000;
            m_stage = ST_NONE;
            m_left  = 0;
        end else begin
            if (m_stage == ST_FIR) exp_fir_edges++;
            if (m_stage == ST_FFT) exp_fft_edges++;
            if (m_stage == ST_DMA) exp_dma_edges++;
            case (m_stage)
                ST_NONE: if (ready_for_processing) m_stage = m_cfg[0] ? ST_FFT : ST_FIR;
                ST_FIR:  if (fir_done) begin m_stage = ST_DMA; m_left = BS; end
                ST_FFT:  if (fft_done) begin m_stage = ST_DMA; m_left = BS; end
                default: begin
                    m_left--;
                    if (m_left == 0) m_stage = ST_NONE;
                end
            endcase
            if (write_enable) m_cfg = config_in;
        end
    end

    // Per-cycle comparison against the model while clk is low (gated clocks must be low too).
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("config_mode", 32'(config_mode), 32'(m_cfg));
            checkOutput("start_fir", 32'(start_fir), 32'(m_stage == ST_FIR));
            checkOutput("start_fft", 32'(start_fft), 32'(m_stage == ST_FFT));
            checkOutput("start_dma_out", 32'(start_dma_out), 32'(m_stage == ST_DMA));
            checkOutput("processing_active", 32'(processing_active), 32'(m_stage != ST_NONE));
            checkOutput("gated_low", {29'd0, clk_fir, clk_fft, clk_dma}, 32'd0);
        end
    end

    // Gated clock edge counters and high-pulse width checks.
    always @(posedge clk_fir) begin act_fir_edges++; rise_fir = $time; end
    always @(posedge clk_fft) begin act_fft_edges++; rise_fft = $time; end
    always @(posedge clk_dma) begin act_dma_edges++; rise_dma = $time; end
    always @(negedge clk_fir) checkOutput("clk_fir_pulse", 32'(($time - rise_fir) >= HALF), 32'd1);
    always @(negedge clk_fft) checkOutput("clk_fft_pulse", 32'(($time - rise_fft) >= HALF), 32'd1);
    always @(negedge clk_dma) checkOutput("clk_dma_pulse", 32'(($time - rise_dma) >= HALF), 32'd1);

    // Drive one cycle of inputs (called at a negedge) and move to the next negedge.
    task automatic applyStimulus(input logic we, input logic [4:0] cfg, input logic rdy,
                                 input logic fird, input logic fftd);
        write_enable         = we;
        config_in            = cfg;
        ready_for_processing = rdy;
        fir_done             = fird;
        fft_done             = fftd;
        @(negedge clk);
    endtask

    // Count DMA cycles until the unit returns to idle, bounded.
    task automatic measureDma(output int cycles, output bit done);
        cycles = 0;
        done   = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            if (start_dma_out) cycles++;
            if (!processing_active) done = 1'b1;
            else applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic checkEdges();
        checkOutput("clk_fir_edges", 32'(act_fir_edges), 32'(exp_fir_edges));
        checkOutput("clk_fft_edges", 32'(act_fft_edges), 32'(exp_fft_edges));
        checkOutput("clk_dma_edges", 32'(act_dma_edges), 32'(exp_dma_edges));
    endtask

    initial begin
        int  cyc;
        bit  ok;
        int  fft_before;
        reset                = 1'b1;
        write_enable         = 1'b0;
        config_in            = 5'b00000;
        ready_for_processing = 1'b0;
        fir_done             = 1'b0;
        fft_done             = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        checkOutput("reset_config", 32'(config_mode), 32'd0);
        checkOutput("reset_active", 32'(processing_active), 32'd0);
        checkOutput("reset_starts", {29'd0, start_fir, start_fft, start_dma_out}, 32'd0);
        reset = 1'b0;

        // Config writes.
        applyStimulus(1'b1, 5'b00001, 1'b0, 1'b0, 1'b0);
        checkOutput("cfg_write", 32'(config_mode), 32'h01);
        applyStimulus(1'b0, 5'b10110, 1'b0, 1'b0, 1'b0);
        checkOutput("cfg_hold", 32'(config_mode), 32'h01);

        // FFT run.
        applyStimulus(1'b0, 5'b00000, 1'b1, 1'b0, 1'b0);
        checkOutput("fft_start", 32'(start_fft), 32'd1);
        checkOutput("fft_active", 32'(processing_active), 32'd1);
        fft_before = act_fft_edges;
        repeat (20) applyStimulus(1'b0, 5'b00000, 1'b0, 1'b1 & 1'b0, 1'b0);
        checkOutput("fft_edges_20", 32'(act_fft_edges - fft_before), 32'd20);
        applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
        checkOutput("fft_to_dma", {30'd0, start_fft, start_dma_out}, 32'd1);
        measureDma(cyc, ok);
        checkOutput("fft_dma_done", 32'(ok), 32'd1);
        checkOutput("fft_dma_len", 32'(cyc), 32'd256);
        checkEdges();

        // FIR run with a spurious fft_done and a mid-run config write.
        applyStimulus(1'b1, 5'b00000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'b00000, 1'b1, 1'b0, 1'b0);
        checkOutput("fir_start", 32'(start_fir), 32'd1);
        applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
        checkOutput("fir_ignores_fft_done", 32'(start_fir), 32'd1);
        applyStimulus(1'b1, 5'b00001, 1'b0, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
        checkOutput("fir_stays_fir", 32'(start_fir), 32'd1);
        applyStimulus(1'b0, 5'b00000, 1'b0, 1'b1, 1'b0);
        checkOutput("fir_to_dma", 32'(start_dma_out), 32'd1);
        measureDma(cyc, ok);
        checkOutput("fir_dma_done", 32'(ok), 32'd1);
        checkOutput("fir_dma_len", 32'(cyc), 32'd256);

        // Next run uses the FFT path written during FIR; reset it mid-DMA.
        applyStimulus(1'b0, 5'b00000, 1'b1, 1'b0, 1'b0);
        checkOutput("next_run_fft", 32'(start_fft), 32'd1);
        repeat (3) applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
        repeat (50) applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_dma", 32'(start_dma_out), 32'd0);
        checkOutput("rst_active", 32'(processing_active), 32'd0);
        checkOutput("rst_config", 32'(config_mode), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 5'b00000, 1'b1, 1'b0, 1'b0);
        checkOutput("restart_fir", 32'(start_fir), 32'd1);
        checkEdges();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(15) == 0), 5'($urandom),
                          ($urandom_range(3) == 0), ($urandom_range(15) == 0),
                          ($urandom_range(15) == 0));
        end
        applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
        checkEdges();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
